tmds_channel_decoder: RTL and testbench



---
 rtl/tmds_channel_decoder.sv | 151 +++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment by bitslip search, lock tracking, and
// 10b->8b decode of data words plus control-token recovery.
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS    = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_SETTLE    = 16,
  parameter int LOSS_TIMEOUT   = 1048576
) (
  input  logic       pixclk,
  input  logic       reset,
  input  logic [9:0] tmds_in,
  output logic       bitslip,
  output logic       locked,
  output logic [7:0] VD,
  output logic [1:0] CD,
  output logic       VDE,
  output logic [3:0] slip_cnt
);
  localparam int RUN_W = $clog2(LOCK_TOKENS) + 1;
  localparam int TMO_W = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int SET_W = $clog2(SLIP_SETTLE) + 1;
  localparam int GAP_W = $clog2(LOSS_TIMEOUT) + 1;

  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_TOKENS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(LOSS_TIMEOUT);

  typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_t;

  state_t           r_state;
  logic [9:0]       r_w;
  logic [RUN_W-1:0] r_run;
  logic [TMO_W-1:0] r_tmo;
  logic [SET_W-1:0] r_settle;
  logic [GAP_W-1:0] r_gap;

  logic             w_tok;
  logic [1:0]       w_cd;
  logic [7:0]       w_d;
  logic [7:0]       w_vd;
  logic [RUN_W-1:0] w_run_nxt;
  logic [GAP_W-1:0] w_gap_nxt;
  logic             w_lock_hit;
  logic             w_loss_hit;
  logic             w_tmo_hit;
  logic             w_settle_done;
  logic             w_lock_nxt;

  always_comb begin
    w_tok = 1'b1;
    w_cd  = 2'b00;
    case (r_w)
      10'b1101010100: w_cd = 2'b00;
      10'b0010101011: w_cd = 2'b01;
      10'b0101010100: w_cd = 2'b10;
      10'b1010101011: w_cd = 2'b11;
      default:        w_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  assign w_d = r_w[9] ? ~r_w[7:0] : r_w[7:0];

  always_comb begin
    w_vd    = '0;
    w_vd[0] = w_d[0];
    for (int i = 1; i < 8; i++)
      w_vd[i] = r_w[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
  end

  assign w_run_nxt     = (r_run == RUN_MAX) ? RUN_MAX : r_run + RUN_W'(1);
  assign w_gap_nxt     = (r_gap == GAP_MAX) ? GAP_MAX : r_gap + GAP_W'(1);
  assign w_lock_hit    = w_tok && (w_run_nxt == RUN_MAX);
  assign w_loss_hit    = !w_tok && (w_gap_nxt == GAP_MAX);
  assign w_tmo_hit     = (r_tmo == TMO_LAST);
  assign w_settle_done = (r_settle == SET_LAST);
  // Lock state as of this edge; VDE/VD follow it so loss gates the same word.
  assign w_lock_nxt    = ((r_state == SEARCH) && w_lock_hit) ||
                         ((r_state == LOCKED) && !w_loss_hit);

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_state  <= SEARCH;
      r_w      <= '0;
      r_run    <= '0;
      r_tmo    <= '0;
      r_settle <= '0;
      r_gap    <= '0;
      bitslip  <= 1'b0;
      locked   <= 1'b0;
      VD       <= '0;
      CD       <= '0;
      VDE      <= 1'b0;
      slip_cnt <= '0;
    end else begin
      r_w     <= tmds_in;
      bitslip <= 1'b0;
      locked  <= w_lock_nxt;
      if (w_tok) begin
        CD  <= w_cd;
        VD  <= '0;
        VDE <= 1'b0;
      end else begin
        VDE <= w_lock_nxt;
        VD  <= w_lock_nxt ? w_vd : '0;
      end
      case (r_state)
        SEARCH: begin
          if (w_lock_hit) begin
            r_state <= LOCKED;
            r_run   <= '0;
            r_tmo   <= '0;
            r_gap   <= '0;
          end else if (w_tmo_hit) begin
            r_state  <= SLIP_WAIT;
            bitslip  <= 1'b1;
            slip_cnt <= slip_cnt + 4'd1;
            r_run    <= '0;
            r_tmo    <= '0;
            r_settle <= '0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
            r_run <= w_tok ? w_run_nxt : '0;
          end
        end
        SLIP_WAIT: begin
          if (w_settle_done) begin
            r_state  <= SEARCH;
            r_settle <= '0;
            r_run    <= '0;
            r_tmo    <= '0;
          end else begin
            r_settle <= r_settle + SET_W'(1);
          end
        end
        LOCKED: begin
          if (w_loss_hit) begin
            r_state <= SEARCH;
            r_gap   <= '0;
            r_run   <= '0;
            r_tmo   <= '0;
          end else begin
            r_gap <= w_tok ? '0 : w_gap_nxt;
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: data words come from a TMDS
// encoder model so expected pixels are the encoder inputs.
module tb_tmds_channel_decoder;
  localparam logic [9:0] TK0 = 10'b1101010100;
  localparam logic [9:0] TK1 = 10'b0010101011;
  localparam logic [9:0] TK2 = 10'b0101010100;
  localparam logic [9:0] TK3 = 10'b1010101011;

  logic       pixclk = 1'b0;
  logic       reset  = 1'b0;
  logic [9:0] tmds_in = '0;
  logic       bitslip, locked, VDE;
  logic [7:0] VD;
  logic [1:0] CD;
  logic [3:0] slip_cnt;

  typedef struct {
    string      tag;
    logic       lk;
    logic       vde;
    logic       bs;
    logic [3:0] sc;
    logic       cvd;
    logic [7:0] vd;
    logic       ccd;
    logic [1:0] cd;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  tmds_channel_decoder #(
    .LOCK_TOKENS(8), .SEARCH_TIMEOUT(32), .SLIP_SETTLE(4), .LOSS_TIMEOUT(64)
  ) dut (
    .pixclk(pixclk), .reset(reset), .tmds_in(tmds_in), .bitslip(bitslip),
    .locked(locked), .VD(VD), .CD(CD), .VDE(VDE), .slip_cnt(slip_cnt)
  );

  always #5 pixclk = ~pixclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic lk, input logic vde,
                              input logic bs, input logic [3:0] sc, input logic cvd,
                              input logic [7:0] vd, input logic ccd, input logic [1:0] cd);
    exp_t e;
    e.tag = tag; e.lk = lk; e.vde = vde; e.bs = bs; e.sc = sc;
    e.cvd = cvd; e.vd = vd; e.ccd = ccd; e.cd = cd;
    return e;
  endfunction

  // Transmit-side encoding of a pixel with a random XOR/XNOR and inversion choice.
  task automatic gen_data(output logic [9:0] w, output logic [7:0] px);
    logic [7:0] qm;
    logic       xn, inv;
    do begin
      px    = 8'($urandom);
      xn    = 1'($urandom);
      inv   = 1'($urandom);
      qm[0] = px[0];
      for (int i = 1; i < 8; i++)
        qm[i] = xn ? ~(qm[i-1] ^ px[i]) : (qm[i-1] ^ px[i]);
      w = {inv, ~xn, inv ? ~qm : qm};
    end while (w == TK0 || w == TK1 || w == TK2 || w == TK3);
  endtask

  // Called at a negedge; the word driven two calls earlier is visible now.
  task automatic step(input logic [9:0] word, input exp_t e);
    exp_t h;
    if (q.size() >= 2) begin
      h = q.pop_front();
      chk({h.tag, ".locked"},   {31'd0, locked},  {31'd0, h.lk});
      chk({h.tag, ".vde"},      {31'd0, VDE},     {31'd0, h.vde});
      chk({h.tag, ".bitslip"},  {31'd0, bitslip}, {31'd0, h.bs});
      chk({h.tag, ".slip_cnt"}, {28'd0, slip_cnt}, {28'd0, h.sc});
      if (h.cvd) chk({h.tag, ".vd"}, {24'd0, VD}, {24'd0, h.vd});
      if (h.ccd) chk({h.tag, ".cd"}, {30'd0, CD}, {30'd0, h.cd});
    end
    tmds_in = word;
    q.push_back(e);
    @(negedge pixclk);
  endtask

  // Reset lands mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge pixclk);
    #2;
    tmds_in = 10'($urandom);
    reset = 1'b1;
    #1;
    chk("rst.bitslip",  {31'd0, bitslip}, 0);
    chk("rst.locked",   {31'd0, locked},  0);
    chk("rst.vde",      {31'd0, VDE},     0);
    chk("rst.vd",       {24'd0, VD},      0);
    chk("rst.cd",       {30'd0, CD},      0);
    chk("rst.slip_cnt", {28'd0, slip_cnt}, 0);
    @(negedge pixclk);
    @(negedge pixclk);
    q.delete();
    tmds_in = '0;
    reset = 1'b0;
  endtask

  initial begin
    logic [9:0] w;
    logic [7:0] px;
    logic [3:0] sc;
    logic       bs;

    #1 reset = 1'b1;
    do_reset();

    // Lock acquisition, decode, CD hold, and loss of lock.
    for (int i = 0; i < 7; i++) step(TK0, mk("a.tok", 0, 0, 0, 0, 0, 0, 1, 2'b00));
    step(10'b0100000000, mk("a.brk", 0, 0, 0, 0, 1, 8'h00, 1, 2'b00));
    for (int i = 0; i < 7; i++) step(TK0, mk("a.run", 0, 0, 0, 0, 0, 0, 1, 2'b00));
    step(TK0, mk("a.lock", 1, 0, 0, 0, 0, 0, 1, 2'b00));
    step(10'b0100000000, mk("a.d00", 1, 1, 0, 0, 1, 8'h00, 1, 2'b00));
    step(10'b1011111111, mk("a.dfe", 1, 1, 0, 0, 1, 8'hFE, 1, 2'b00));
    step(10'b0111111111, mk("a.d01", 1, 1, 0, 0, 1, 8'h01, 1, 2'b00));
    step(TK2, mk("a.tk2", 1, 0, 0, 0, 0, 0, 1, 2'b10));
    for (int i = 0; i < 63; i++) begin
      gen_data(w, px);
      step(w, mk("a.gap63", 1, 1, 0, 0, 1, px, 1, 2'b10));
    end
    step(TK3, mk("a.tk3", 1, 0, 0, 0, 0, 0, 1, 2'b11));
    for (int i = 0; i < 63; i++) begin
      gen_data(w, px);
      step(w, mk("a.gap64", 1, 1, 0, 0, 1, px, 1, 2'b11));
    end
    gen_data(w, px);
    step(w, mk("a.loss", 0, 0, 0, 0, 1, 8'h00, 1, 2'b11));
    for (int i = 0; i < 31; i++) begin
      gen_data(w, px);
      step(w, mk("a.srch", 0, 0, 0, 0, 1, 8'h00, 1, 2'b11));
    end
    gen_data(w, px);
    step(w, mk("a.slip", 0, 0, 1, 1, 1, 8'h00, 1, 2'b11));
    for (int i = 0; i < 4; i++) begin
      gen_data(w, px);
      step(w, mk("a.wait", 0, 0, 0, 1, 1, 8'h00, 1, 2'b11));
    end
    for (int i = 0; i < 7; i++) step(TK3, mk("a.run2", 0, 0, 0, 1, 0, 0, 1, 2'b11));
    step(TK3, mk("a.lock2", 1, 0, 0, 1, 0, 0, 1, 2'b11));
    step(10'b0111111111, mk("a.d01b", 1, 1, 0, 1, 1, 8'h01, 1, 2'b11));
    step(10'b0111111111, mk("a.d01c", 1, 1, 0, 1, 1, 8'h01, 1, 2'b11));
    do_reset();

    // Data-only search: periodic bitslip, ignored tokens while settling, wrap.
    sc = 4'd0;
    for (int s = 1; s <= 580; s++) begin
      bs = (s >= 31) && (((s - 31) % 36) == 0);
      if (bs) sc = sc + 4'd1;
      if (s >= 32 && s <= 42) begin
        step(TK0, mk("b.tok", 0, 0, bs, sc, 0, 0, 1, 2'b00));
      end else begin
        gen_data(w, px);
        step(w, mk("b.slip", 0, 0, bs, sc, 1, 8'h00, 1, 2'b00));
      end
    end
    do_reset();

    // Eighth token on the same cycle as the search timeout: lock wins.
    for (int s = 1; s <= 23; s++) begin
      gen_data(w, px);
      step(w, mk("c.pre", 0, 0, 0, 0, 1, 8'h00, 1, 2'b00));
    end
    for (int s = 24; s <= 30; s++) step(TK1, mk("c.run", 0, 0, 0, 0, 0, 0, 1, 2'b01));
    step(TK1, mk("c.coin", 1, 0, 0, 0, 0, 0, 1, 2'b01));
    for (int i = 0; i < 42; i++) begin
      gen_data(w, px);
      step(w, mk("c.post", 1, 1, 0, 0, 1, px, 1, 2'b01));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
